// File: rtl/mips_pkg.sv
// Shared definitions for the ID/EX stage: ALU op codes, datapath width defaults
// and the forwarding-select encoding reported by fwd_mux.
package mips_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_REG_AW = 5;

    localparam logic [3:0] ALU_AND = 4'd0;
    localparam logic [3:0] ALU_OR  = 4'd1;
    localparam logic [3:0] ALU_NOR = 4'd2;
    localparam logic [3:0] ALU_ADD = 4'd3;
    localparam logic [3:0] ALU_SUB = 4'd4;
    localparam logic [3:0] ALU_LUI = 4'd5;
    localparam logic [3:0] ALU_SLL = 4'd6;
    localparam logic [3:0] ALU_SRL = 4'd7;

    typedef enum logic [1:0] {
        FWD_REG   = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2
    } fwd_sel_t;

endpackage

// File: rtl/fwd_mux.sv
// Operand bypass for one source register. The youngest producer (EX/MEM)
// wins over MEM/WB, and register $0 is never forwarded.
module fwd_mux
    import mips_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_AW = DEF_REG_AW
) (
    input  logic [REG_AW-1:0] src,
    input  logic [DATA_W-1:0] reg_data,
    input  logic              exmem_reg_write,
    input  logic [REG_AW-1:0] exmem_dest,
    input  logic [DATA_W-1:0] exmem_result,
    input  logic              memwb_reg_write,
    input  logic [REG_AW-1:0] memwb_dest,
    input  logic [DATA_W-1:0] memwb_result,
    output fwd_sel_t          sel,
    output logic [DATA_W-1:0] fwd_data
);

    // Pick the forwarding source for this operand.
    always_comb begin
        sel      = FWD_REG;
        fwd_data = reg_data;
        if (exmem_reg_write && (exmem_dest != '0) && (exmem_dest == src)) begin
            sel      = FWD_EXMEM;
            fwd_data = exmem_result;
        end else if (memwb_reg_write && (memwb_dest != '0) && (memwb_dest == src)) begin
            sel      = FWD_MEMWB;
            fwd_data = memwb_result;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register in front of the ALU: captures one decoded
// instruction per cycle, forwards operands from EX/MEM and MEM/WB, and inserts
// one bubble on a load-use hazard.
// Optional: define HAZARD_CNT_EN to add the bubble_count load-use counter.
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_AW = DEF_REG_AW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_alu_op,
    input  logic [DATA_W-1:0] in_rs_data,
    input  logic [DATA_W-1:0] in_rt_data,
    input  logic [DATA_W-1:0] in_imm,
    input  logic [4:0]        in_shamt,
    input  logic              in_alu_src,
    input  logic [REG_AW-1:0] in_rs,
    input  logic [REG_AW-1:0] in_rt,
    input  logic [REG_AW-1:0] in_dest,
    input  logic              in_uses_rt,
    input  logic              in_reg_write,
    input  logic              in_mem_read,
    input  logic              in_mem_write,
    input  logic              in_mem_to_reg,
    input  logic              stall,
    input  logic              flush,
    input  logic              exmem_reg_write,
    input  logic [REG_AW-1:0] exmem_dest,
    input  logic [DATA_W-1:0] exmem_result,
    input  logic              memwb_reg_write,
    input  logic [REG_AW-1:0] memwb_dest,
    input  logic [DATA_W-1:0] memwb_result,
    output logic [3:0]        alu_operation,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [4:0]        alu_shamt,
    output logic              ex_valid,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_mem_to_reg,
    output logic [REG_AW-1:0] ex_dest,
    output logic [DATA_W-1:0] ex_store_data
`ifdef HAZARD_CNT_EN
    ,
    output logic [31:0]       bubble_count
`endif
);

    logic [REG_AW-1:0] rs_q;
    logic [REG_AW-1:0] rt_q;
    logic [DATA_W-1:0] rs_data_q;
    logic [DATA_W-1:0] rt_data_q;
    logic [DATA_W-1:0] imm_q;
    logic              alu_src_q;
    logic              load_use;
    fwd_sel_t          rs_sel;
    fwd_sel_t          rt_sel;
    logic [DATA_W-1:0] rs_fwd;
    logic [DATA_W-1:0] rt_fwd;

    // A load still in EX cannot supply its data yet; hold decode for one cycle.
    always_comb begin
        load_use = ex_valid && ex_mem_read && (ex_dest != '0) && in_valid &&
                   ((in_rs == ex_dest) || (in_uses_rt && (in_rt == ex_dest)));
        in_ready = !stall && !load_use;
    end

    // Pipeline register: reset > flush > stall > load-use bubble > capture > bubble.
    // Bubbles clear only the control fields; data fields are left as they are.
    always_ff @(posedge clk) begin
        if (reset) begin
            rs_q          <= '0;
            rt_q          <= '0;
            rs_data_q     <= '0;
            rt_data_q     <= '0;
            imm_q         <= '0;
            alu_src_q     <= 1'b0;
            alu_operation <= ALU_AND;
            alu_shamt     <= '0;
            ex_dest       <= '0;
            ex_valid      <= 1'b0;
            ex_reg_write  <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_mem_to_reg <= 1'b0;
        end else if (flush || (!stall && (load_use || !in_valid))) begin
            ex_valid      <= 1'b0;
            ex_reg_write  <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_mem_to_reg <= 1'b0;
        end else if (!stall) begin
            rs_q          <= in_rs;
            rt_q          <= in_rt;
            rs_data_q     <= in_rs_data;
            rt_data_q     <= in_rt_data;
            imm_q         <= in_imm;
            alu_src_q     <= in_alu_src;
            alu_operation <= in_alu_op;
            alu_shamt     <= in_shamt;
            ex_dest       <= in_dest;
            ex_valid      <= 1'b1;
            ex_reg_write  <= in_reg_write;
            ex_mem_read   <= in_mem_read;
            ex_mem_write  <= in_mem_write;
            ex_mem_to_reg <= in_mem_to_reg;
        end
    end

    fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs (
        .src             (rs_q),
        .reg_data        (rs_data_q),
        .exmem_reg_write (exmem_reg_write),
        .exmem_dest      (exmem_dest),
        .exmem_result    (exmem_result),
        .memwb_reg_write (memwb_reg_write),
        .memwb_dest      (memwb_dest),
        .memwb_result    (memwb_result),
        .sel             (rs_sel),
        .fwd_data        (rs_fwd)
    );

    fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rt (
        .src             (rt_q),
        .reg_data        (rt_data_q),
        .exmem_reg_write (exmem_reg_write),
        .exmem_dest      (exmem_dest),
        .exmem_result    (exmem_result),
        .memwb_reg_write (memwb_reg_write),
        .memwb_dest      (memwb_dest),
        .memwb_result    (memwb_result),
        .sel             (rt_sel),
        .fwd_data        (rt_fwd)
    );

    // Operand drive: the non-forwarded case reads the flop directly so the
    // common path does not pass through the bypass comparators.
    always_comb begin
        alu_a         = (rs_sel == FWD_REG) ? rs_data_q : rs_fwd;
        ex_store_data = (rt_sel == FWD_REG) ? rt_data_q : rt_fwd;
        alu_b         = alu_src_q ? imm_q : ex_store_data;
    end

`ifdef HAZARD_CNT_EN
    // Count load-use bubbles only; flush bubbles and stalled cycles are excluded.
    always_ff @(posedge clk) begin
        if (reset) begin
            bubble_count <= '0;
        end else if (!flush && !stall && load_use) begin
            bubble_count <= bubble_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    in_alu_op;
    logic [DW-1:0] in_rs_data, in_rt_data, in_imm;
    logic [4:0]    in_shamt;
    logic          in_alu_src;
    logic [AW-1:0] in_rs, in_rt, in_dest;
    logic          in_uses_rt, in_reg_write, in_mem_read, in_mem_write, in_mem_to_reg;
    logic          stall, flush;
    logic          exmem_reg_write, memwb_reg_write;
    logic [AW-1:0] exmem_dest, memwb_dest;
    logic [DW-1:0] exmem_result, memwb_result;
    logic [3:0]    alu_operation;
    logic [DW-1:0] alu_a, alu_b, ex_store_data;
    logic [4:0]    alu_shamt;
    logic          ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
    logic [AW-1:0] ex_dest;
`ifdef HAZARD_CNT_EN
    logic [31:0]   bubble_count;
`endif

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [3:0]    op;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] store;
        logic [AW-1:0] dest;
        logic          mem_write;
    } exp_t;

    exp_t exp_q[$];

    id_ex_stage dut (
        .clk             (clk),
        .reset           (reset),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_alu_op       (in_alu_op),
        .in_rs_data      (in_rs_data),
        .in_rt_data      (in_rt_data),
        .in_imm          (in_imm),
        .in_shamt        (in_shamt),
        .in_alu_src      (in_alu_src),
        .in_rs           (in_rs),
        .in_rt           (in_rt),
        .in_dest         (in_dest),
        .in_uses_rt      (in_uses_rt),
        .in_reg_write    (in_reg_write),
        .in_mem_read     (in_mem_read),
        .in_mem_write    (in_mem_write),
        .in_mem_to_reg   (in_mem_to_reg),
        .stall           (stall),
        .flush           (flush),
        .exmem_reg_write (exmem_reg_write),
        .exmem_dest      (exmem_dest),
        .exmem_result    (exmem_result),
        .memwb_reg_write (memwb_reg_write),
        .memwb_dest      (memwb_dest),
        .memwb_result    (memwb_result),
        .alu_operation   (alu_operation),
        .alu_a           (alu_a),
        .alu_b           (alu_b),
        .alu_shamt       (alu_shamt),
        .ex_valid        (ex_valid),
        .ex_reg_write    (ex_reg_write),
        .ex_mem_read     (ex_mem_read),
        .ex_mem_write    (ex_mem_write),
        .ex_mem_to_reg   (ex_mem_to_reg),
        .ex_dest         (ex_dest),
        .ex_store_data   (ex_store_data)
`ifdef HAZARD_CNT_EN
        ,
        .bubble_count    (bubble_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 0; in_alu_op = 0; in_rs_data = 0; in_rt_data = 0; in_imm = 0;
        in_shamt = 0; in_alu_src = 0; in_rs = 0; in_rt = 0; in_dest = 0;
        in_uses_rt = 0; in_reg_write = 0; in_mem_read = 0; in_mem_write = 0;
        in_mem_to_reg = 0; stall = 0; flush = 0;
        exmem_reg_write = 0; exmem_dest = 0; exmem_result = 0;
        memwb_reg_write = 0; memwb_dest = 0; memwb_result = 0;
    endtask

    task automatic drive_instr(input logic [3:0] op, input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                               input logic [AW-1:0] dest, input logic [DW-1:0] rsd,
                               input logic [DW-1:0] rtd, input logic [DW-1:0] imm,
                               input logic src, input logic uses_rt, input logic mrd, input logic mwr);
        in_valid = 1; in_alu_op = op; in_rs = rs; in_rt = rt; in_dest = dest;
        in_rs_data = rsd; in_rt_data = rtd; in_imm = imm; in_alu_src = src;
        in_uses_rt = uses_rt; in_mem_read = mrd; in_mem_write = mwr;
        in_reg_write = !mwr; in_mem_to_reg = mrd; in_shamt = 5'd3;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1;
        drive_instr(4'd3, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick(); tick();
        tests++; if (alu_operation !== 4'd0) begin fails++; $display("FAIL reset_op got %0d exp 0", alu_operation); end
        tests++; if (ex_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %0b exp 0", ex_valid); end
        tests++; if (alu_a !== 32'd0) begin fails++; $display("FAIL reset_alu_a got %h exp 0", alu_a); end
        reset = 0;
        idle_inputs();
    endtask

    task automatic test_capture();
        exp_t e;
        drive_instr(4'd3, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'h99, 1'b0, 1'b1, 1'b0, 1'b0);
        exp_q.push_back('{op: 4'd3, a: 32'd5, b: 32'd7, store: 32'd7, dest: 5'd3, mem_write: 1'b0});
        tick();
        in_valid = 0;
        e = exp_q.pop_front();
        tests++; if (alu_operation !== e.op) begin fails++; $display("FAIL capture_op got %0d exp %0d", alu_operation, e.op); end
        tests++; if (alu_a !== e.a) begin fails++; $display("FAIL capture_a got %h exp %h", alu_a, e.a); end
        tests++; if (alu_b !== e.b) begin fails++; $display("FAIL capture_b got %h exp %h", alu_b, e.b); end
        tests++; if (ex_valid !== 1'b1) begin fails++; $display("FAIL capture_valid got %0b exp 1", ex_valid); end
        tests++; if (alu_shamt !== 5'd3) begin fails++; $display("FAIL capture_shamt got %0d exp 3", alu_shamt); end
        tick();
        tests++; if (ex_valid !== 1'b0) begin fails++; $display("FAIL idle_bubble got %0b exp 0", ex_valid); end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            logic [DW-1:0] rsd, rtd, imm;
            logic [3:0] op;
            logic src;
            rsd = $urandom; rtd = $urandom; imm = $urandom;
            op = 4'(i * 3 + 1);
            src = i[0];
            drive_instr(op, 5'(i + 1), 5'(i + 10), 5'(i + 20), rsd, rtd, imm, src, 1'b1, 1'b0, 1'b0);
            exp_q.push_back('{op: op, a: rsd, b: src ? imm : rtd, store: rtd, dest: 5'(i + 20), mem_write: 1'b0});
            tick();
            e = exp_q.pop_front();
            tests++;
            if (alu_operation !== e.op || alu_a !== e.a || alu_b !== e.b || ex_dest !== e.dest || ex_valid !== 1'b1) begin
                fails++;
                $display("FAIL b2b_%0d got op=%0d a=%h b=%h d=%0d v=%0b exp op=%0d a=%h b=%h d=%0d v=1",
                         i, alu_operation, alu_a, alu_b, ex_dest, ex_valid, e.op, e.a, e.b, e.dest);
            end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_forward();
        drive_instr(4'd1, 5'd8, 5'd9, 5'd4, 32'hAA, 32'hBB, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        in_valid = 0;
        exmem_reg_write = 1; exmem_dest = 5'd8; exmem_result = 32'h11;
        memwb_reg_write = 1; memwb_dest = 5'd8; memwb_result = 32'h22;
        #1;
        tests++; if (alu_a !== 32'h11) begin fails++; $display("FAIL fwd_exmem_prio got %h exp 11", alu_a); end
        exmem_reg_write = 0;
        #1;
        tests++; if (alu_a !== 32'h22) begin fails++; $display("FAIL fwd_memwb got %h exp 22", alu_a); end
        memwb_dest = 5'd9; memwb_result = 32'h33;
        exmem_reg_write = 1; exmem_dest = 5'd5;
        #1;
        tests++; if (alu_a !== 32'hAA) begin fails++; $display("FAIL fwd_none got %h exp aa", alu_a); end
        tests++; if (ex_store_data !== 32'h33 || alu_b !== 32'h33) begin
            fails++; $display("FAIL fwd_rt got store=%h b=%h exp 33", ex_store_data, alu_b); end
        idle_inputs();
        drive_instr(4'd3, 5'd0, 5'd0, 5'd4, 32'h5A5A, 32'h6B6B, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        in_valid = 0;
        exmem_reg_write = 1; exmem_dest = 5'd0; exmem_result = 32'h11;
        memwb_reg_write = 1; memwb_dest = 5'd0; memwb_result = 32'h22;
        #1;
        tests++; if (alu_a !== 32'h5A5A) begin fails++; $display("FAIL fwd_r0_a got %h exp 5a5a", alu_a); end
        tests++; if (alu_b !== 32'h6B6B) begin fails++; $display("FAIL fwd_r0_b got %h exp 6b6b", alu_b); end
        idle_inputs();
        tick();
    endtask

    task automatic test_load_use();
        exp_t e;
        int lo;
        bit accepted;
        drive_instr(4'd3, 5'd1, 5'd0, 5'd9, 32'h100, 32'h0, 32'h4, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        drive_instr(4'd4, 5'd9, 5'd2, 5'd10, 32'hDEAD, 32'h10, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        exp_q.push_back('{op: 4'd4, a: 32'h1234, b: 32'h10, store: 32'h10, dest: 5'd10, mem_write: 1'b0});
        lo = 0;
        accepted = 0;
        for (int i = 0; i < 6 && !accepted; i++) begin
            #1;
            if (in_ready) accepted = 1;
            else lo++;
            tick();
            if (!accepted) begin
                tests++;
                if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0) begin
                    fails++; $display("FAIL lu_bubble got v=%0b rw=%0b exp 0 0", ex_valid, ex_reg_write);
                end
            end
        end
        in_valid = 0;
        tests++; if (!accepted) begin fails++; $display("FAIL lu_timeout got no accept exp accept"); end
        tests++; if (lo != 1) begin fails++; $display("FAIL lu_stall_cycles got %0d exp 1", lo); end
        memwb_reg_write = 1; memwb_dest = 5'd9; memwb_result = 32'h1234;
        #1;
        e = exp_q.pop_front();
        tests++; if (alu_operation !== e.op || ex_valid !== 1'b1) begin
            fails++; $display("FAIL lu_issue got op=%0d v=%0b exp op=%0d v=1", alu_operation, ex_valid, e.op); end
        tests++; if (alu_a !== e.a) begin fails++; $display("FAIL lu_fwd_a got %h exp %h", alu_a, e.a); end
        tests++; if (alu_b !== e.b) begin fails++; $display("FAIL lu_b got %h exp %h", alu_b, e.b); end
        idle_inputs();
        tick();
    endtask

    task automatic test_flush_stall();
        exp_t e;
        drive_instr(4'd3, 5'd3, 5'd4, 5'd0, 32'h40, 32'h77, 32'h8, 1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        drive_instr(4'd2, 5'd5, 5'd6, 5'd7, 32'h1, 32'h2, 32'h3, 1'b0, 1'b1, 1'b0, 1'b1);
        flush = 1; stall = 1;
        tick();
        tests++; if (ex_valid !== 1'b0 || ex_mem_write !== 1'b0) begin
            fails++; $display("FAIL flush_stall got v=%0b mw=%0b exp 0 0", ex_valid, ex_mem_write); end
        flush = 0; stall = 0;
        drive_instr(4'd3, 5'd3, 5'd4, 5'd0, 32'h40, 32'h77, 32'h8, 1'b1, 1'b1, 1'b0, 1'b1);
        exp_q.push_back('{op: 4'd3, a: 32'h40, b: 32'h8, store: 32'h77, dest: 5'd0, mem_write: 1'b1});
        tick();
        e = exp_q.pop_front();
        drive_instr(4'd7, 5'd11, 5'd12, 5'd13, 32'h5, 32'h6, 32'h7, 1'b0, 1'b1, 1'b0, 1'b0);
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL stall_ready_%0d got %0b exp 0", i, in_ready); end
            tick();
            tests++;
            if (alu_operation !== e.op || alu_a !== e.a || alu_b !== e.b || ex_store_data !== e.store ||
                ex_mem_write !== e.mem_write || ex_valid !== 1'b1) begin
                fails++;
                $display("FAIL stall_hold_%0d got op=%0d a=%h b=%h sd=%h mw=%0b v=%0b exp op=%0d a=%h b=%h sd=%h mw=%0b v=1",
                         i, alu_operation, alu_a, alu_b, ex_store_data, ex_mem_write, ex_valid,
                         e.op, e.a, e.b, e.store, e.mem_write);
            end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_mid_stall();
        drive_instr(4'd3, 5'd1, 5'd0, 5'd9, 32'h0, 32'h0, 32'h4, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        drive_instr(4'd4, 5'd9, 5'd2, 5'd10, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        stall = 1;
        tick();
        reset = 1;
        tick();
        reset = 0; stall = 0;
        #1;
        tests++; if (ex_valid !== 1'b0 || ex_mem_read !== 1'b0 || alu_operation !== 4'd0) begin
            fails++; $display("FAIL rst_mid_stall got v=%0b mr=%0b op=%0d exp 0 0 0", ex_valid, ex_mem_read, alu_operation); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_mid_ready got %0b exp 1", in_ready); end
        idle_inputs();
        tick();
    endtask

`ifdef HAZARD_CNT_EN
    task automatic test_bubble_count();
        reset = 1;
        tick();
        reset = 0;
        tests++; if (bubble_count !== 32'd0) begin fails++; $display("FAIL cnt_reset got %0d exp 0", bubble_count); end
        for (int h = 0; h < 2; h++) begin
            drive_instr(4'd3, 5'd1, 5'd0, 5'd9, 32'h0, 32'h0, 32'h4, 1'b1, 1'b0, 1'b1, 1'b0);
            tick();
            drive_instr(4'd4, 5'd9, 5'd2, 5'd10, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
            tick();
            tick();
            in_valid = 0;
        end
        drive_instr(4'd1, 5'd2, 5'd3, 5'd4, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        flush = 1;
        tick();
        idle_inputs();
        tick();
        tests++; if (bubble_count !== 32'd2) begin fails++; $display("FAIL cnt_value got %0d exp 2", bubble_count); end
    endtask
`endif

    initial begin
        idle_inputs();
        reset = 1;
        test_reset();
        test_capture();
        test_back_to_back();
        test_forward();
        test_load_use();
        test_flush_stall();
        test_reset_mid_stall();
`ifdef HAZARD_CNT_EN
        test_bubble_count();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
